adder_tree_in_packer: RTL and testbench

Upstream feeder for the CSA adder tree. It collects a serial stream of I_DATA_W-bit samples into I_DATA_N-word frames and presents each frame on a packed parallel bus in the tree's input format. It double-buffers with a valid/ready handshake on both sides. A latency-matched tag line marks the cycle on which the tree's o_data belongs to a transferred frame.

---
 rtl/adder_tree_pkg.sv | 20 ++
 rtl/adder_tree_tag_pipe.sv | 32 +++
 rtl/adder_tree_in_packer.sv | 110 +++++++++++
 tb/tb_adder_tree_in_packer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// Shared definitions for the CSA adder tree and its input packer.
// Stage-count and width helpers plus the packed frame type macro.
`define ADDER_TREE_FRAME_T(W, N) logic [0:(N)-1][(W)-1:0]

package adder_tree_pkg;

  localparam int DEF_DATA_W = 3;
  localparam int DEF_DATA_N = 8;

  function automatic int tree_lat(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W = cnt_w(DEF_DATA_N);

endpackage

// File: rtl/adder_tree_tag_pipe.sv
// Single-bit delay line that tracks frames through the free-running tree.
// Depth equals the tree's register stage count.
module adder_tree_tag_pipe #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_one
      // single stage: plain flop
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= 1'b0;
        else        sr <= d;
      end
    end else begin : g_many
      // shift the tag one stage per cycle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[DEPTH-2:0], d};
      end
    end
  endgenerate

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/adder_tree_in_packer.sv
// Serial-to-frame packer feeding the CSA adder tree, double buffered.
// A tag line marks the cycle the tree sum of a taken frame appears.
module adder_tree_in_packer
  import adder_tree_pkg::*;
#(
  parameter  int I_DATA_W = 3,
  parameter  int I_DATA_N = 8,
  parameter  int TREE_LAT = tree_lat(I_DATA_N),
  localparam int CNT_W    = cnt_w(I_DATA_N)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [I_DATA_W-1:0]                i_data,
  input  logic                               i_valid,
  input  logic                               i_last,
  output logic                               o_ready,
  output logic [0:I_DATA_N-1][I_DATA_W-1:0]  o_data,
  output logic [CNT_W-1:0]                   o_cnt,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic                               o_tree_valid
);

  typedef `ADDER_TREE_FRAME_T(I_DATA_W, I_DATA_N) frame_t;

  frame_t           fill_buf;
  frame_t           merged;
  logic [CNT_W-1:0] fill_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             fill_full;
  logic             accept;
  logic             complete;
  logic             take;
  logic             last_word;

  assign o_ready   = !fill_full;
  assign accept    = i_valid && !fill_full;
  assign last_word = (fill_cnt == CNT_W'(I_DATA_N - 1));
  assign complete  = accept && (last_word || i_last);
  assign take      = o_valid && i_ready;
  assign cnt_inc   = fill_cnt + CNT_W'(1);

  // FILL with the current sample dropped in; words above it stay zero
  always_comb begin
    merged = '0;
    for (int i = 0; i < I_DATA_N; i++) begin
      if (CNT_W'(i) < fill_cnt)
        merged[i] = fill_buf[i];
      else if (CNT_W'(i) == fill_cnt)
        merged[i] = i_data;
    end
  end

  // FILL/OUT double buffer with frame completion and handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_buf  <= '0;
      fill_cnt  <= '0;
      fill_full <= 1'b0;
      o_data    <= '0;
      o_cnt     <= '0;
      o_valid   <= 1'b0;
    end else if (fill_full) begin
      if (take) begin
        o_data    <= fill_buf;
        o_cnt     <= cnt_inc;
        o_valid   <= 1'b1;
        fill_buf  <= '0;
        fill_cnt  <= '0;
        fill_full <= 1'b0;
      end
    end else if (complete) begin
      if (!o_valid || take) begin
        o_data   <= merged;
        o_cnt    <= cnt_inc;
        o_valid  <= 1'b1;
        fill_buf <= '0;
        fill_cnt <= '0;
      end else begin
        fill_buf  <= merged;
        fill_full <= 1'b1;
      end
    end else begin
      if (accept) begin
        fill_buf <= merged;
        fill_cnt <= cnt_inc;
      end
      if (take)
        o_valid <= 1'b0;
    end
  end

  adder_tree_tag_pipe #(
    .DEPTH (TREE_LAT)
  ) u_tag (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (take),
    .q     (o_tree_valid)
  );

  a_fill_cnt: assert property (
    @(posedge clk) disable iff (!rst_n)
    fill_cnt <= CNT_W'(I_DATA_N - 1));

  a_o_cnt: assert property (
    @(posedge clk) disable iff (!rst_n)
    o_cnt <= CNT_W'(I_DATA_N));

endmodule

// File: tb/tb_adder_tree_in_packer.sv
// Scoreboard bench for adder_tree_in_packer.
// Frame-level reference model; monitor checks each taken frame.
module tb_adder_tree_in_packer;

  localparam int W   = 3;
  localparam int N   = 8;
  localparam int LAT = 4;
  localparam int CW  = $clog2(N + 1);

  typedef logic [0:N-1][W-1:0] frame_t;
  typedef struct {
    frame_t d;
    int     cnt;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [W-1:0]        i_data;
  logic                i_valid;
  logic                i_last;
  logic                o_ready;
  logic [0:N-1][W-1:0] o_data;
  logic [CW-1:0]       o_cnt;
  logic                o_valid;
  logic                i_ready;
  logic                o_tree_valid;

  adder_tree_in_packer #(
    .I_DATA_W (W),
    .I_DATA_N (N),
    .TREE_LAT (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .i_last       (i_last),
    .o_ready      (o_ready),
    .o_data       (o_data),
    .o_cnt        (o_cnt),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_tree_valid (o_tree_valid)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad   = 0;
  exp_t         exp_q[$];
  logic [W-1:0] cur[$];
  int           pend;
  bit           tq[$];

  task automatic chk(input string name, input longint act,
                     input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur.delete();
    pend = 0;
    tq.delete();
    repeat (LAT) tq.push_back(1'b0);
  endtask

  task automatic step(input bit v, input logic [W-1:0] d,
                      input bit l, input bit r);
    bit   acc;
    bit   tk;
    exp_t e;
    @(posedge clk);
    #1;
    i_valid = v;
    i_data  = d;
    i_last  = l;
    i_ready = r;
    chk("o_ready", o_ready, pend < 2);
    chk("o_valid", o_valid, pend > 0);
    chk("o_tree_valid", o_tree_valid, tq[0]);
    acc = v && (pend < 2);
    tk  = (pend > 0) && r;
    void'(tq.pop_front());
    tq.push_back(tk);
    if (tk) pend--;
    if (acc) begin
      cur.push_back(d);
      if (cur.size() == N || l) begin
        e.d   = '0;
        e.cnt = cur.size();
        for (int i = 0; i < cur.size(); i++) e.d[i] = cur[i];
        exp_q.push_back(e);
        cur.delete();
        pend++;
      end
    end
  endtask

  task automatic async_reset();
    #2;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_tree_valid", o_tree_valid, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_o_cnt", o_cnt, 0);
    chk("rst_o_ready", o_ready, 1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // monitor: compare every frame the DUT hands over
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("o_data", o_data, e.d);
          chk("o_cnt", o_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    i_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("init_o_valid", o_valid, 0);
    chk("init_o_data", o_data, 0);
    chk("init_o_cnt", o_cnt, 0);
    chk("init_o_tree_valid", o_tree_valid, 0);
    chk("init_o_ready", o_ready, 1);
    rst_n = 1'b1;

    // full frame 1..8
    for (int i = 1; i <= 8; i++) step(1, W'(i), 0, 1);
    repeat (6) step(0, 0, 0, 1);

    // short frame closed by i_last
    step(1, 5, 0, 1);
    step(1, 6, 0, 1);
    step(1, 7, 1, 1);
    repeat (6) step(0, 0, 0, 1);

    // backpressure: two frames, 17th sample refused
    for (int i = 0; i < 17; i++) step(1, W'(i + 2), 0, 0);
    repeat (3) step(0, 0, 0, 1);
    repeat (6) step(0, 0, 0, 1);

    // four back-to-back frames
    for (int i = 0; i < 32; i++) step(1, W'($urandom), 0, 1);
    repeat (8) step(0, 0, 0, 1);

    // reset with OUT valid, FILL partial, tags in flight
    for (int i = 0; i < 16; i++) step(1, W'(i), 0, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, W'(i + 4), 0, 0);
    async_reset();
    for (int i = 0; i < 8; i++) step(1, W'(i + 1), 0, 1);
    repeat (6) step(0, 0, 0, 1);

    // i_last without valid, then on the first sample
    step(0, 5, 1, 1);
    step(1, 3, 1, 1);
    repeat (6) step(0, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(0, 3) != 0, W'($urandom),
           $urandom_range(0, 9) == 0,
           (i % 500 < 250) ? ($urandom_range(0, 3) != 0)
                           : ($urandom_range(0, 3) == 0));
      if (i == 1200) async_reset();
    end

    repeat (20) step(0, 0, 0, 1);
    chk("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
